// File: rtl/cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_memory_responder
// Purpose  : Memory-side responder for CPU instruction fetch and data access.
//            64x16 loadable instruction store (1-cycle registered fetch) and
//            64x16 data RAM with a RAM_RD_LAT-deep registered read pipeline.
//            Simultaneous read+write drops the read and sets a sticky flag.
// Options  : MEM_ACCESS_COUNT_EN adds saturating rd_count / wr_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_memory_responder #(
  parameter int                   ADDR_W        = 6,
  parameter int                   DATA_W        = 16,
  parameter int                   RAM_RD_LAT    = 1,
  parameter logic [DATA_W-1:0]    ROM_INIT_WORD = 16'hFF00
) (
  input  logic              clk_main,
  input  logic              reset,
  // instruction fetch
  input  logic [ADDR_W-1:0] address_to_rom,
  input  logic              enable_to_rom,
  output logic [DATA_W-1:0] data_from_rom,
  output logic              rom_valid,
  // data memory
  input  logic [ADDR_W-1:0] address_to_ram,
  input  logic              write_enable_to_ram,
  input  logic              read_enable_to_ram,
  input  logic [DATA_W-1:0] data_to_ram,
  output logic [DATA_W-1:0] data_from_ram,
  output logic              ram_read_valid,
  // program load
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`ifdef MEM_ACCESS_COUNT_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
`endif
  output logic              collision
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  // Read latency outside 1..3 is rejected at elaboration.
  if (RAM_RD_LAT < 1 || RAM_RD_LAT > 3) begin : g_lat_check
    $error("cpu_memory_responder: RAM_RD_LAT must be in 1..3");
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  // The instruction store powers up filled with the halt opcode and is never
  // touched by reset, so a loaded program survives a CPU reset.
  logic [DATA_W-1:0] r_rom [c_DEPTH] = '{default: ROM_INIT_WORD};
  logic [DATA_W-1:0] r_ram [c_DEPTH];

  logic [DATA_W-1:0] r_rom_data;
  logic              r_rom_valid;
  logic              r_collision;

  // Read pipeline: each stage carries {valid, data}; the last stage drives out.
  logic              r_pv    [RAM_RD_LAT];
  logic [DATA_W-1:0] r_pd    [RAM_RD_LAT];
  logic              w_src_v [RAM_RD_LAT];
  logic [DATA_W-1:0] w_src_d [RAM_RD_LAT];

  // A read colliding with a write is dropped; the write still happens.
  logic w_rd_accept;
  logic w_collide;
  assign w_collide   = read_enable_to_ram & write_enable_to_ram;
  assign w_rd_accept = read_enable_to_ram & ~write_enable_to_ram;

  // Program-load port; ignored while reset is held.
  always_ff @(posedge clk_main) begin
    if (!reset && prog_we) begin
      r_rom[prog_addr] <= prog_data;
    end
  end

  // Instruction fetch: registered read, so a same-edge program write is not seen.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      r_rom_data  <= '0;
      r_rom_valid <= 1'b0;
    end else begin
      r_rom_valid <= enable_to_rom;
      if (enable_to_rom) begin
        r_rom_data <= r_rom[address_to_rom];
      end
    end
  end

  // Data RAM write port; reset clears every word.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_ram[i] <= '0;
      end
    end else if (write_enable_to_ram) begin
      r_ram[address_to_ram] <= data_to_ram;
    end
  end

  // Stage inputs: stage 0 samples the pre-edge RAM word, later stages chain.
  always_comb begin
    w_src_v[0] = w_rd_accept;
    w_src_d[0] = r_ram[address_to_ram];
    for (int i = 1; i < RAM_RD_LAT; i++) begin
      w_src_v[i] = r_pv[i-1];
      w_src_d[i] = r_pd[i-1];
    end
  end

  // Read pipeline shift; data only advances with a valid token, so the output
  // word holds its last returned value across bubbles.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      for (int i = 0; i < RAM_RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RAM_RD_LAT; i++) begin
        r_pv[i] <= w_src_v[i];
        if (w_src_v[i]) begin
          r_pd[i] <= w_src_d[i];
        end
      end
    end
  end

  // Sticky collision flag, cleared only by reset.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      r_collision <= 1'b0;
    end else if (w_collide) begin
      r_collision <= 1'b1;
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  // Saturating access counters; collision reads are not counted.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_accept && r_rd_count != 16'hFFFF) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (write_enable_to_ram && r_wr_count != 16'hFFFF) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

  assign data_from_rom  = r_rom_data;
  assign rom_valid      = r_rom_valid;
  assign data_from_ram  = r_pd[RAM_RD_LAT-1];
  assign ram_read_valid = r_pv[RAM_RD_LAT-1];
  assign collision      = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_memory_responder
// Purpose  : Scoreboard bench. Two responders (read latency 3 and 1) share one
//            stimulus stream; expected responses are queued with the cycle
//            they are due and popped by a monitor on each valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_memory_responder;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  address_to_rom;
  logic        enable_to_rom;
  logic [5:0]  address_to_ram;
  logic        write_enable_to_ram;
  logic        read_enable_to_ram;
  logic [15:0] data_to_ram;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [15:0] prog_data;

  logic [15:0] rom_d3, ram_d3, rom_d1, ram_d1;
  logic        rom_v3, ram_v3, rom_v1, ram_v1, coll3, coll1;
`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] rdc3, wrc3, rdc1, wrc1;
`endif

  exp_t q3[$];
  exp_t q1[$];
  exp_t qr[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   rd_exp = 0;
  int   wr_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_memory_responder #(.RAM_RD_LAT(3)) u_dut (
    .clk_main(clk), .reset(reset),
    .address_to_rom(address_to_rom), .enable_to_rom(enable_to_rom),
    .data_from_rom(rom_d3), .rom_valid(rom_v3),
    .address_to_ram(address_to_ram), .write_enable_to_ram(write_enable_to_ram),
    .read_enable_to_ram(read_enable_to_ram), .data_to_ram(data_to_ram),
    .data_from_ram(ram_d3), .ram_read_valid(ram_v3),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`ifdef MEM_ACCESS_COUNT_EN
    .rd_count(rdc3), .wr_count(wrc3),
`endif
    .collision(coll3)
  );

  cpu_memory_responder #(.RAM_RD_LAT(1)) u_dut1 (
    .clk_main(clk), .reset(reset),
    .address_to_rom(address_to_rom), .enable_to_rom(enable_to_rom),
    .data_from_rom(rom_d1), .rom_valid(rom_v1),
    .address_to_ram(address_to_ram), .write_enable_to_ram(write_enable_to_ram),
    .read_enable_to_ram(read_enable_to_ram), .data_to_ram(data_to_ram),
    .data_from_ram(ram_d1), .ram_read_valid(ram_v1),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`ifdef MEM_ACCESS_COUNT_EN
    .rd_count(rdc1), .wr_count(wrc1),
`endif
    .collision(coll1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_resp(input string name, input logic [15:0] got, input exp_t e);
    n_vec++;
    if (got !== e.d || cyc != e.due) begin
      n_fail++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
               name, got, cyc, e.d, e.due);
    end
  endtask

  task automatic fetch(input logic [5:0] a, input logic [15:0] e);
    enable_to_rom  = 1'b1;
    address_to_rom = a;
    qr.push_back('{d: e, due: cyc + 1});
    tick();
    enable_to_rom = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    write_enable_to_ram = 1'b1;
    address_to_ram      = a;
    data_to_ram         = d;
    wr_exp++;
    tick();
    write_enable_to_ram = 1'b0;
  endtask

  // push3=0 marks a read that the latency-3 responder will lose to a reset.
  task automatic do_read(input logic [5:0] a, input logic [15:0] e, input bit push3);
    read_enable_to_ram = 1'b1;
    address_to_ram     = a;
    q1.push_back('{d: e, due: cyc + 1});
    if (push3) q3.push_back('{d: e, due: cyc + 3});
    rd_exp++;
    tick();
    read_enable_to_ram = 1'b0;
  endtask

  // Monitor: every valid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ram_v3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL ram_lat3_unexpected: got %h at cycle %0d, expected no strobe", ram_d3, cyc);
      end else begin
        e = q3.pop_front();
        cmp_resp("ram_lat3", ram_d3, e);
      end
    end
    if (ram_v1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL ram_lat1_unexpected: got %h at cycle %0d, expected no strobe", ram_d1, cyc);
      end else begin
        e = q1.pop_front();
        cmp_resp("ram_lat1", ram_d1, e);
      end
    end
    if (rom_v3 === 1'b1) begin
      if (qr.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL rom_unexpected: got %h at cycle %0d, expected no strobe", rom_d3, cyc);
      end else begin
        e = qr.pop_front();
        cmp_resp("rom_fetch", rom_d3, e);
      end
    end
  end

  initial begin
    reset = 1'b1;
    address_to_rom = '0; enable_to_rom = 1'b0;
    address_to_ram = '0; write_enable_to_ram = 1'b0; read_enable_to_ram = 1'b0;
    data_to_ram = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (3) tick();

    chk("rst_data_from_rom", rom_d3, 16'h0);
    chk("rst_rom_valid", {15'd0, rom_v3}, 16'h0);
    chk("rst_data_from_ram", ram_d3, 16'h0);
    chk("rst_ram_read_valid", {15'd0, ram_v3}, 16'h0);
    chk("rst_collision", {15'd0, coll3}, 16'h0);
    reset = 1'b0;

    // Program load, then a fetch racing a program write to the same address.
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = 16'h8006; tick();
    prog_addr = 6'd1; prog_data = 16'h8211; tick();
    prog_addr = 6'd2; prog_data = 16'h1111;
    fetch(6'd2, 16'hFF00);
    prog_we = 1'b0;
    fetch(6'd0, 16'h8006);
    fetch(6'd1, 16'h8211);
    fetch(6'd2, 16'h1111);
    tick(); tick();
    chk("rom_idle_valid", {15'd0, rom_v3}, 16'h0);
    chk("rom_idle_hold", rom_d3, 16'h1111);

    // Write then read, plus read-before-write ordering on address 5.
    do_write(6'd3, 16'h0321);
    do_read(6'd3, 16'h0321, 1'b1);
    do_write(6'd5, 16'h0013);
    do_read(6'd5, 16'h0013, 1'b1);
    do_write(6'd5, 16'hAAAA);
    do_read(6'd5, 16'hAAAA, 1'b1);

    // Collision: write happens, read is dropped, flag sticks.
    read_enable_to_ram = 1'b1; write_enable_to_ram = 1'b1;
    address_to_ram = 6'd7; data_to_ram = 16'h1234;
    wr_exp++;
    tick();
    read_enable_to_ram = 1'b0; write_enable_to_ram = 1'b0;
    tick();
    chk("collision_set_lat3", {15'd0, coll3}, 16'h1);
    chk("collision_set_lat1", {15'd0, coll1}, 16'h1);
    do_read(6'd3, 16'h0321, 1'b1);
    do_read(6'd5, 16'hAAAA, 1'b1);
    do_read(6'd7, 16'h1234, 1'b1);
    repeat (6) tick();
    chk("collision_sticky", {15'd0, coll3}, 16'h1);
`ifdef MEM_ACCESS_COUNT_EN
    chk("rd_count", rdc3, rd_exp[15:0]);
    chk("wr_count", wrc3, wr_exp[15:0]);
`endif

    // Reset behind three back-to-back reads; only the oldest latency-3 read
    // leaves the pipe before the reset edge. Fetch and program write during
    // reset must both be ignored.
    do_read(6'd3, 16'h0321, 1'b1);
    do_read(6'd5, 16'hAAAA, 1'b0);
    do_read(6'd7, 16'h1234, 1'b0);
    reset = 1'b1;
    enable_to_rom = 1'b1; address_to_rom = 6'd0;
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = 16'h0000;
    tick(); tick();
    reset = 1'b0; enable_to_rom = 1'b0; prog_we = 1'b0;
    rd_exp = 0; wr_exp = 0;
    chk("midrst_data_from_rom", rom_d3, 16'h0);
    chk("midrst_rom_valid", {15'd0, rom_v3}, 16'h0);
    chk("midrst_data_from_ram", ram_d3, 16'h0);
    chk("midrst_ram_read_valid", {15'd0, ram_v3}, 16'h0);
    chk("midrst_collision", {15'd0, coll3}, 16'h0);
    repeat (4) tick();
    do_read(6'd3, 16'h0000, 1'b1);
    fetch(6'd0, 16'h8006);
    repeat (6) tick();

    chk("drain_q3", q3.size(), 16'h0);
    chk("drain_q1", q1.size(), 16'h0);
    chk("drain_rom", qr.size(), 16'h0);
`ifdef MEM_ACCESS_COUNT_EN
    chk("rd_count_post_rst", rdc3, rd_exp[15:0]);
    chk("wr_count_post_rst", wrc3, wr_exp[15:0]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
